rat_flag_int_unit: RTL
======================

Name: rat_flag_int_unit

Overview:
Flag and interrupt-control block that sits on the far side of the ALU's flag interface. It latches the ALU's C/Z outputs into architectural flags and feeds C back as the ALU carry-in. It also owns the interrupt-enable flag, the shadow C/Z pair, and a small interrupt FSM that exchanges a request/acknowledge handshake with the control unit.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the INTR_IN synchroniser (min 2).
EDGE_TRIG, 1, 1 = INTR_IN rising edge sets pending; 0 = INTR_IN level sets pending every cycle it is high.

Ports:
CLK  in  1  system clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
ALU_C  in  1  carry out from ALU.
ALU_Z  in  1  zero out from ALU.
FLG_C_LD  in  1  load C from ALU_C.
FLG_Z_LD  in  1  load Z from ALU_Z.
FLG_C_SET  in  1  C <= 1 (SEC).
FLG_C_CLR  in  1  C <= 0 (CLC).
I_SET  in  1  I <= 1 (SEI).
I_CLR  in  1  I <= 0 (CLI).
RETI  in  1  return from interrupt; restores C/Z from shadow.
RETI_EN  in  1  qualifies RETI: I <= RETI_EN (RETIE=1, RETID=0).
INTR_IN  in  1  external interrupt request, asynchronous.
INT_ACK  in  1  control unit takes the interrupt this cycle.
C_FLAG  out  1  C flag; drives ALU CIN.
Z_FLAG  out  1  Z flag.
I_FLAG  out  1  interrupt-enable flag.
INT_PEND  out  1  interrupt request to control unit.
IN_ISR  out  1  high while the FSM is in ISR.

Behaviour:
- Reset (RST_N=0, asynchronous): C, Z, I, SHAD_C, SHAD_Z, pend, synchroniser and edge register all 0; FSM in RUN. All outputs are 0 during reset and until the first qualifying update.
- All register updates occur on the rising CLK edge. Outputs reflect registers and are visible the cycle after a command.
- C priority, highest first: INT_ACK (hold) > RETI (SHAD_C) > FLG_C_CLR > FLG_C_SET > FLG_C_LD (ALU_C) > hold.
- Z priority, highest first: INT_ACK (hold) > RETI (SHAD_Z) > FLG_Z_LD (ALU_Z) > hold.
- I priority, highest first: INT_ACK (0) > RETI (RETI_EN) > I_CLR (0) > I_SET (1) > hold.
- Synchroniser: INTR_IN passes through SYNC_STAGES flops.
  - EDGE_TRIG=1: pend sets on the synced 0->1 transition.
  - EDGE_TRIG=0: pend sets whenever the synced value is 1.
- pend clears on INT_ACK in state PEND. If a set and a clear coincide, set wins, so an edge arriving during the ack cycle is not lost.
- FSM states RUN, PEND, ISR:
  - RUN: pend & I -> PEND; otherwise stay.
  - PEND: INT_ACK -> ISR; SHAD_C/SHAD_Z <= current C/Z; I <= 0; pend cleared. Else if I=0 (CLI issued) -> RUN, with pend retained. Else stay.
  - ISR: RETI -> RUN. Other commands operate normally. New requests latch in pend and are serviced after RETI only if I=1.
- INT_PEND = (state==PEND), combinational from the state register. IN_ISR = (state==ISR).
- Latency: with I=1, EDGE_TRIG=1 and FSM in RUN, INT_PEND rises after exactly SYNC_STAGES+2 rising edges, counted from the first edge that samples INTR_IN=1.
- INT_ACK outside PEND is ignored: no state, flag or pend change.
- RETI outside ISR still restores C/Z from shadow and loads I from RETI_EN; the state does not change.
- Nesting is not supported. A single shadow level is used, and I=0 in ISR unless software issues SEI.
- Reset mid-ISR or mid-PEND returns the FSM to RUN and discards any pending request.

Decomposition:
- Shared package rat_pkg: enum fsm_int_t {RUN, PEND, ISR} (2-bit); localparam flag-bit indices C_IDX=0, Z_IDX=1.
- One sub-module: sync_edge_det, holding the SYNC_STAGES-deep synchroniser plus rising-edge detector. It has parameters SYNC_STAGES and EDGE_TRIG, uses async active-low reset, and outputs a one-cycle pulse (or level).

Test Plan:
- Flag loads: ALU_C=1, ALU_Z=1, FLG_C_LD=FLG_Z_LD=1 for one cycle -> C_FLAG=1, Z_FLAG=1 next cycle. Then FLG_C_SET with FLG_C_CLR, both 1 -> C_FLAG=0 (CLR wins), Z unchanged.
- Interrupt entry: I_SET, C=1, Z=0, pulse INTR_IN high -> INT_PEND=1 exactly 4 edges later (SYNC_STAGES=2). Assert INT_ACK -> next cycle IN_ISR=1, I_FLAG=0, INT_PEND=0, SHAD={C=1,Z=0}.
- Interrupt return: in ISR, load C=0, Z=1 from the ALU, then RETI with RETI_EN=1 -> C_FLAG=1, Z_FLAG=0, I_FLAG=1, IN_ISR=0. A second RETI with RETI_EN=0 -> I_FLAG=0.
- Masking: I=0, pulse INTR_IN -> INT_PEND stays 0. I_SET -> INT_PEND=1 two cycles later. CLI while in PEND -> INT_PEND=0 next cycle, pend retained, and it re-asserts after SEI.
- Request during ISR: INTR_IN edge while IN_ISR=1 -> INT_PEND stays 0. RETIE -> RUN, then INT_PEND=1 one cycle later.
- Async reset mid-PEND: drop RST_N between clock edges -> all outputs 0 immediately. After release, with no new INTR_IN edge, INT_PEND remains 0.

Source files
------------

// File: rtl/rat_pkg.sv
// Shared types for the flag/interrupt unit: interrupt FSM encoding and flag-bit indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rat_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        ISR  = 2'd2
    } fsm_int_t;

    localparam int C_IDX = 0;
    localparam int Z_IDX = 1;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronises an asynchronous request through SYNC_STAGES flops, then rising-edge detects it.
// Latency: SYNC_STAGES edges from din to the synced value; pulse is combinational from the flops.
// Backpressure: none; pulse is a one-cycle strobe (EDGE_TRIG=1) or the synced level (EDGE_TRIG=0).
module sync_edge_det #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_TRIG   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    generate
        if (EDGE_TRIG) begin : g_edge
            logic prev_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_q <= 1'b0;
                end else begin
                    prev_q <= sync_q[SYNC_STAGES-1];
                end
            end

            assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
        end else begin : g_level
            assign pulse = sync_q[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/rat_flag_int_unit.sv
// Architectural C/Z/I flags, single-level C/Z shadow, and the RUN/PEND/ISR interrupt handshake FSM.
// Latency: flag commands visible one cycle later; INTR_IN edge to INT_PEND is SYNC_STAGES+2 edges.
// Backpressure: INT_PEND holds until INT_ACK; requests arriving outside RUN wait in pend.
module rat_flag_int_unit
    import rat_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_TRIG   = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic ALU_C,
    input  logic ALU_Z,
    input  logic FLG_C_LD,
    input  logic FLG_Z_LD,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic RETI,
    input  logic RETI_EN,
    input  logic INTR_IN,
    input  logic INT_ACK,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic I_FLAG,
    output logic INT_PEND,
    output logic IN_ISR
);

    fsm_int_t   state_q;
    fsm_int_t   state_nxt;
    logic [1:0] flags_q;
    logic [1:0] flags_nxt;
    logic [1:0] shad_q;
    logic       i_q;
    logic       i_nxt;
    logic       pend_q;
    logic       pend_nxt;
    logic       pend_set;
    logic       ack;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TRIG   (EDGE_TRIG)
    ) u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .din   (INTR_IN),
        .pulse (pend_set)
    );

    // An acknowledge only counts while a request is actually being offered.
    assign ack = INT_ACK && (state_q == PEND);

    always_comb begin
        flags_nxt = flags_q;
        if (ack) begin
            flags_nxt = flags_q;
        end else if (RETI) begin
            flags_nxt = shad_q;
        end else begin
            if (FLG_C_CLR) begin
                flags_nxt[C_IDX] = 1'b0;
            end else if (FLG_C_SET) begin
                flags_nxt[C_IDX] = 1'b1;
            end else if (FLG_C_LD) begin
                flags_nxt[C_IDX] = ALU_C;
            end
            if (FLG_Z_LD) begin
                flags_nxt[Z_IDX] = ALU_Z;
            end
        end
    end

    always_comb begin
        i_nxt = i_q;
        if (ack) begin
            i_nxt = 1'b0;
        end else if (RETI) begin
            i_nxt = RETI_EN;
        end else if (I_CLR) begin
            i_nxt = 1'b0;
        end else if (I_SET) begin
            i_nxt = 1'b1;
        end
    end

    // A new request coinciding with the ack wins, so it is not lost.
    always_comb begin
        pend_nxt = pend_q;
        if (pend_set) begin
            pend_nxt = 1'b1;
        end else if (ack) begin
            pend_nxt = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            RUN: begin
                if (pend_q && i_q) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                // Withdraw the request in the same cycle a CLI lands; pend is kept.
                if (ack) begin
                    state_nxt = ISR;
                end else if (!i_nxt) begin
                    state_nxt = RUN;
                end
            end
            ISR: begin
                if (RETI) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= RUN;
            flags_q <= '0;
            shad_q  <= '0;
            i_q     <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            flags_q <= flags_nxt;
            i_q     <= i_nxt;
            pend_q  <= pend_nxt;
            if (ack) begin
                shad_q <= flags_q;
            end
        end
    end

    assign C_FLAG   = flags_q[C_IDX];
    assign Z_FLAG   = flags_q[Z_IDX];
    assign I_FLAG   = i_q;
    assign INT_PEND = (state_q == PEND);
    assign IN_ISR   = (state_q == ISR);

endmodule
